// File: rtl/branch_pc_unit.sv
// Next-PC / branch-resolution stage.
// Owns the architectural PC and picks PC+4, the branch target or the JAL target.
// After any taken redirect the wrong-path slot is flushed for FLUSH_CYCLES cycles.
// A saturating counter of taken redirects is kept for the perf readout.
module branch_pc_unit #(
  parameter int unsigned       DBITS        = 32,
  parameter logic [DBITS-1:0]  START_PC     = DBITS'(32'h40),
  parameter int unsigned       FLUSH_CYCLES = 1,
  parameter int unsigned       CNT_BITS     = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                stall,
  input  logic                inst_valid,
  input  logic                is_branch,
  input  logic                is_jal,
  input  logic                cond_in,
  input  logic [DBITS-1:0]    br_offset,
  input  logic [DBITS-1:0]    jal_base,
  input  logic [DBITS-1:0]    jal_offset,
  output logic [DBITS-1:0]    pc_out,
  output logic                fetch_req,
  output logic [DBITS-1:0]    link_out,
  output logic                flush,
  output logic                misalign,
  output logic [CNT_BITS-1:0] taken_cnt
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_FLUSH
  } state_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  state_t              r_state;
  logic [DBITS-1:0]    r_pc;
  logic [2:0]          r_fcnt;
  logic                r_fetch;
  logic                r_flush;
  logic                r_mis;
  logic [CNT_BITS-1:0] r_cnt;

  logic [DBITS-1:0]    w_link;
  logic [DBITS-1:0]    w_jal_raw;
  logic [DBITS-1:0]    w_br_tgt;
  logic [DBITS-1:0]    w_next_pc;
  logic                w_taken;
  logic                w_cnt_sat;

  // Next-PC candidates and selection; JAL wins over a simultaneous branch
  always_comb begin
    w_link    = r_pc + DBITS'(4);
    w_jal_raw = jal_base + (jal_offset << 2);
    w_br_tgt  = w_link + (br_offset << 2);
    w_taken   = is_jal | (is_branch & cond_in);
    w_cnt_sat = &r_cnt;
    if (is_jal) begin
      w_next_pc = {w_jal_raw[DBITS-1:2], 2'b00};
    end else if (is_branch && cond_in) begin
      w_next_pc = w_br_tgt;
    end else begin
      w_next_pc = w_link;
    end
  end

  // Boot/run/flush sequencing with PC, counter and registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_BOOT;
      r_pc    <= START_PC;
      r_fcnt  <= '0;
      r_fetch <= 1'b0;
      r_flush <= 1'b0;
      r_mis   <= 1'b0;
      r_cnt   <= '0;
    end else if (!stall) begin
      unique case (r_state)
        S_BOOT: begin
          r_state <= S_RUN;
          r_fetch <= 1'b1;
        end
        S_RUN: begin
          r_mis <= 1'b0;
          if (inst_valid) begin
            r_pc <= w_next_pc;
            if (w_taken) begin
              r_state <= S_FLUSH;
              r_flush <= 1'b1;
              r_fcnt  <= FLUSH_LOAD;
              r_mis   <= is_jal & (|w_jal_raw[1:0]);
              if (!w_cnt_sat) begin
                r_cnt <= r_cnt + CNT_BITS'(1);
              end
            end
          end
        end
        S_FLUSH: begin
          r_mis <= 1'b0;
          if (r_fcnt <= 3'd1) begin
            r_state <= S_RUN;
            r_flush <= 1'b0;
          end else begin
            r_fcnt <= r_fcnt - 3'd1;
          end
        end
        default: begin
          r_state <= S_BOOT;
          r_fetch <= 1'b0;
          r_flush <= 1'b0;
        end
      endcase
    end
  end

  assign pc_out    = r_pc;
  assign fetch_req = r_fetch;
  assign link_out  = w_link;
  assign flush     = r_flush;
  assign misalign  = r_mis;
  assign taken_cnt = r_cnt;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Self-checking bench for branch_pc_unit: three instances share stimulus
// (default, FLUSH_CYCLES=3, CNT_BITS=3) and are checked against a
// cycle-level reference model of the next-PC rules.
module tb_branch_pc_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, stall, inst_valid, is_branch, is_jal, cond_in;
  logic [31:0] br_offset, jal_base, jal_offset;

  logic [31:0] pc0, pc1, pc2, lk0, lk1, lk2;
  logic        fr0, fr1, fr2, fl0, fl1, fl2, mi0, mi1, mi2;
  logic [15:0] tc0, tc1;
  logic [2:0]  tc2;

  int n_checks = 0;
  int n_err    = 0;

  branch_pc_unit #(.DBITS(32), .FLUSH_CYCLES(1), .CNT_BITS(16)) dut0 (
    .clk(clk), .reset_n(reset_n), .stall(stall), .inst_valid(inst_valid),
    .is_branch(is_branch), .is_jal(is_jal), .cond_in(cond_in),
    .br_offset(br_offset), .jal_base(jal_base), .jal_offset(jal_offset),
    .pc_out(pc0), .fetch_req(fr0), .link_out(lk0), .flush(fl0),
    .misalign(mi0), .taken_cnt(tc0));

  branch_pc_unit #(.DBITS(32), .FLUSH_CYCLES(3), .CNT_BITS(16)) dut1 (
    .clk(clk), .reset_n(reset_n), .stall(stall), .inst_valid(inst_valid),
    .is_branch(is_branch), .is_jal(is_jal), .cond_in(cond_in),
    .br_offset(br_offset), .jal_base(jal_base), .jal_offset(jal_offset),
    .pc_out(pc1), .fetch_req(fr1), .link_out(lk1), .flush(fl1),
    .misalign(mi1), .taken_cnt(tc1));

  branch_pc_unit #(.DBITS(32), .FLUSH_CYCLES(1), .CNT_BITS(3)) dut2 (
    .clk(clk), .reset_n(reset_n), .stall(stall), .inst_valid(inst_valid),
    .is_branch(is_branch), .is_jal(is_jal), .cond_in(cond_in),
    .br_offset(br_offset), .jal_base(jal_base), .jal_offset(jal_offset),
    .pc_out(pc2), .fetch_req(fr2), .link_out(lk2), .flush(fl2),
    .misalign(mi2), .taken_cnt(tc2));

  // Reference model state, one slot per instance
  logic [31:0] m_pc   [3];
  bit          m_boot [3];
  int          m_left [3];   // flush cycles still to be shown
  int unsigned m_cnt  [3];
  bit          m_mis  [3];
  int          m_nfl  [3] = '{1, 3, 1};
  int unsigned m_cmax [3] = '{65535, 65535, 7};

  task automatic model_update();
    logic [31:0] t;
    bit taken;
    for (int k = 0; k < 3; k++) begin
      taken = 0;
      if (!reset_n) begin
        m_pc[k] = 32'h40; m_boot[k] = 1; m_left[k] = 0; m_cnt[k] = 0; m_mis[k] = 0;
      end else if (stall) begin
        // everything frozen
      end else if (m_boot[k]) begin
        m_boot[k] = 0;
      end else if (m_left[k] > 0) begin
        m_left[k] = m_left[k] - 1;
        m_mis[k]  = 0;
      end else begin
        m_mis[k] = 0;
        if (inst_valid) begin
          if (is_jal) begin
            t = jal_base + jal_offset * 4;
            m_mis[k] = (t % 4) != 0;
            m_pc[k]  = t - (t % 4);
            taken = 1;
          end else if (is_branch && cond_in) begin
            m_pc[k] = m_pc[k] + 4 + br_offset * 4;
            taken = 1;
          end else begin
            m_pc[k] = m_pc[k] + 4;
          end
          if (taken) begin
            m_left[k] = m_nfl[k];
            if (m_cnt[k] < m_cmax[k]) m_cnt[k] = m_cnt[k] + 1;
          end
        end
      end
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic b, input logic j, input logic c,
                       input logic [31:0] bo, input logic [31:0] jb, input logic [31:0] jo);
    inst_valid = v; is_branch = b; is_jal = j; cond_in = c;
    br_offset = bo; jal_base = jb; jal_offset = jo;
  endtask

  function automatic logic [31:0] obs_pc(int k);
    return (k == 0) ? pc0 : (k == 1) ? pc1 : pc2;
  endfunction
  function automatic logic [31:0] obs_lk(int k);
    return (k == 0) ? lk0 : (k == 1) ? lk1 : lk2;
  endfunction
  function automatic logic [2:0] obs_bits(int k); // {fetch_req, flush, misalign}
    return (k == 0) ? {fr0, fl0, mi0} : (k == 1) ? {fr1, fl1, mi1} : {fr2, fl2, mi2};
  endfunction
  function automatic logic [15:0] obs_tc(int k);
    return (k == 0) ? tc0 : (k == 1) ? tc1 : {13'd0, tc2};
  endfunction

  task automatic test_reset();
    stall = 0; reset_n = 0;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    n_checks++; if (pc0 !== 32'h40) begin n_err++; $display("FAIL reset_pc: got %h want %h", pc0, 32'h40); end
    n_checks++; if (fr0 !== 1'b0) begin n_err++; $display("FAIL reset_fetch: got %b want 0", fr0); end
    n_checks++; if (fl0 !== 1'b0) begin n_err++; $display("FAIL reset_flush: got %b want 0", fl0); end
    n_checks++; if (mi0 !== 1'b0) begin n_err++; $display("FAIL reset_misalign: got %b want 0", mi0); end
    n_checks++; if (tc0 !== 16'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", tc0); end
    n_checks++; if (pc1 !== 32'h40 || pc2 !== 32'h40) begin n_err++; $display("FAIL reset_pc_others: got %h %h want 40", pc1, pc2); end
  endtask

  task automatic test_sequential();
    reset_n = 1;
    drive(1, 0, 0, 0, 0, 0, 0);
    tick();
    n_checks++; if (pc0 !== 32'h40 || fr0 !== 1'b1) begin n_err++; $display("FAIL boot_exit: got pc %h fetch %b want 40 1", pc0, fr0); end
    tick();
    n_checks++; if (pc0 !== 32'h44) begin n_err++; $display("FAIL seq_1: got %h want 44", pc0); end
    tick();
    n_checks++; if (pc0 !== 32'h48) begin n_err++; $display("FAIL seq_2: got %h want 48", pc0); end
    n_checks++; if (lk0 !== 32'h4C) begin n_err++; $display("FAIL link_seq: got %h want 4c", lk0); end
  endtask

  task automatic test_branch_taken();
    drive(1, 0, 1, 0, 0, 32'h100, 0);
    tick();
    n_checks++; if (pc0 !== 32'h100 || fl0 !== 1'b1) begin n_err++; $display("FAIL jal_setup: got pc %h flush %b want 100 1", pc0, fl0); end
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 1, 0, 1, 32'hFFFF_FFFE, 0, 0);
    tick();
    n_checks++; if (pc0 !== 32'hFC) begin n_err++; $display("FAIL br_taken_pc: got %h want fc", pc0); end
    n_checks++; if (fl0 !== 1'b1) begin n_err++; $display("FAIL br_taken_flush: got %b want 1", fl0); end
    n_checks++; if (tc0 !== 16'd2) begin n_err++; $display("FAIL br_taken_cnt: got %0d want 2", tc0); end
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    n_checks++; if (fl0 !== 1'b0 || pc0 !== 32'hFC) begin n_err++; $display("FAIL br_flush_end: got flush %b pc %h want 0 fc", fl0, pc0); end
  endtask

  task automatic test_branch_not_taken();
    drive(1, 0, 1, 0, 0, 32'h100, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 1, 0, 0, 32'd5, 0, 0);
    tick();
    n_checks++; if (pc0 !== 32'h104) begin n_err++; $display("FAIL br_nt_pc: got %h want 104", pc0); end
    n_checks++; if (fl0 !== 1'b0) begin n_err++; $display("FAIL br_nt_flush: got %b want 0", fl0); end
    n_checks++; if (tc0 !== 16'd3) begin n_err++; $display("FAIL br_nt_cnt: got %0d want 3", tc0); end
  endtask

  task automatic test_jal_priority();
    n_checks++; if (lk0 !== 32'h108) begin n_err++; $display("FAIL jal_link_prior: got %h want 108", lk0); end
    drive(1, 1, 1, 1, 32'd7, 32'h203, 32'd1);
    tick();
    n_checks++; if (pc0 !== 32'h204) begin n_err++; $display("FAIL jal_prio_pc: got %h want 204", pc0); end
    n_checks++; if (mi0 !== 1'b1 || fl0 !== 1'b1) begin n_err++; $display("FAIL jal_misalign: got mis %b flush %b want 1 1", mi0, fl0); end
    n_checks++; if (tc0 !== 16'd4) begin n_err++; $display("FAIL jal_cnt: got %0d want 4", tc0); end
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    n_checks++; if (mi0 !== 1'b0) begin n_err++; $display("FAIL misalign_pulse: got %b want 0", mi0); end
  endtask

  task automatic test_flush_stall();
    int hi;
    reset_n = 0; drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    reset_n = 1;
    tick();
    drive(1, 0, 1, 0, 0, 32'h300, 0);
    tick();
    hi = 0;
    if (fl1 === 1'b1) hi = 1;
    drive(1, 1, 0, 1, 32'd5, 0, 0);   // would redirect if not ignored
    for (int i = 0; i < 8; i++) begin
      stall = (i == 1);
      tick();
      if (fl1 !== 1'b1) break;
      hi++;
      n_checks++; if (pc1 !== 32'h300) begin n_err++; $display("FAIL flush3_hold_pc: got %h want 300", pc1); end
    end
    stall = 0;
    drive(0, 0, 0, 0, 0, 0, 0);
    n_checks++; if (hi != 4) begin n_err++; $display("FAIL flush3_len: got %0d want 4 cycles", hi); end
    n_checks++; if (pc1 !== 32'h300 || tc1 !== 16'd1) begin n_err++; $display("FAIL flush3_end: got pc %h cnt %0d want 300 1", pc1, tc1); end
  endtask

  task automatic test_wrap();
    drive(0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    drive(1, 0, 1, 0, 0, 32'hFFFF_FFFC, 0);
    tick();
    n_checks++; if (pc0 !== 32'hFFFF_FFFC || mi0 !== 1'b0) begin n_err++; $display("FAIL wrap_setup: got pc %h mis %b want fffffffc 0", pc0, mi0); end
    n_checks++; if (lk0 !== 32'h0) begin n_err++; $display("FAIL wrap_link: got %h want 0", lk0); end
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0);
    tick();
    n_checks++; if (pc0 !== 32'h0 || lk0 !== 32'h4) begin n_err++; $display("FAIL wrap_pc: got pc %h link %h want 0 4", pc0, lk0); end
  endtask

  task automatic test_reset_in_flush();
    drive(1, 0, 1, 0, 0, 32'h500, 0);
    tick();
    n_checks++; if (fl0 !== 1'b1) begin n_err++; $display("FAIL rif_setup: got flush %b want 1", fl0); end
    reset_n = 0; stall = 1;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    n_checks++; if (pc0 !== 32'h40 || fr0 !== 1'b0 || fl0 !== 1'b0) begin n_err++; $display("FAIL rif_state: got pc %h fetch %b flush %b want 40 0 0", pc0, fr0, fl0); end
    n_checks++; if (tc0 !== 16'd0 || tc1 !== 16'd0) begin n_err++; $display("FAIL rif_cnt: got %0d %0d want 0", tc0, tc1); end
    reset_n = 1; stall = 0;
  endtask

  task automatic test_saturation();
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 0, 1, 32'd1, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      tick();
    end
    n_checks++; if (tc2 !== 3'd7) begin n_err++; $display("FAIL sat_cnt3: got %0d want 7", tc2); end
    n_checks++; if (tc0 !== 16'd10) begin n_err++; $display("FAIL sat_cnt16: got %0d want 10", tc0); end
  endtask

  task automatic test_random();
    reset_n = 0; stall = 0; drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    for (int n = 0; n < 400; n++) begin
      reset_n    = ($urandom_range(0, 99) >= 3);
      stall      = ($urandom_range(0, 99) < 20);
      inst_valid = ($urandom_range(0, 99) < 80);
      is_jal     = ($urandom_range(0, 99) < 15);
      is_branch  = ($urandom_range(0, 99) < 30);
      cond_in    = $urandom_range(0, 1);
      br_offset  = 32'($urandom_range(0, 64)) - 32'd32;
      jal_base   = $urandom;
      jal_offset = 32'($urandom_range(0, 64)) - 32'd32;
      tick();
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (obs_pc(k) !== m_pc[k]) begin n_err++; $display("FAIL rnd_pc[%0d] cyc %0d: got %h want %h", k, n, obs_pc(k), m_pc[k]); end
        n_checks++;
        if (obs_lk(k) !== m_pc[k] + 32'd4) begin n_err++; $display("FAIL rnd_link[%0d] cyc %0d: got %h want %h", k, n, obs_lk(k), m_pc[k] + 32'd4); end
        n_checks++;
        if (obs_bits(k) !== {!m_boot[k], m_left[k] > 0, m_mis[k]}) begin
          n_err++; $display("FAIL rnd_ctl[%0d] cyc %0d: got fetch/flush/mis %b want %b", k, n, obs_bits(k), {!m_boot[k], m_left[k] > 0, m_mis[k]});
        end
        n_checks++;
        if (obs_tc(k) !== 16'(m_cnt[k])) begin n_err++; $display("FAIL rnd_cnt[%0d] cyc %0d: got %0d want %0d", k, n, obs_tc(k), m_cnt[k]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch_taken();
    test_branch_not_taken();
    test_jal_priority();
    test_flush_stall();
    test_wrap();
    test_reset_in_flush();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
